// File: rtl/pcie_rx_tlp_router_pkg.sv
// Shared types and sizing for the PCIe RX TLP router: segment record, route tag
// and the helper that extracts the route from tuser.
package pcie_rx_tlp_router_pkg;

   localparam int NUM_CH        = 2;
   localparam int HDR_W         = 128;
   localparam int DATA_W        = 256;
   localparam int USER_W        = 16;
   localparam int ERR_CNT_W     = 16;
   localparam int USER_MMIO_BIT = 0;
   localparam int ORPH_N_W      = $clog2(NUM_CH + 1);

   typedef enum logic {
      ROUTE_CPL  = 1'b0,
      ROUTE_MMIO = 1'b1
   } t_rx_route;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [HDR_W-1:0]  hdr;
      logic [DATA_W-1:0] payload;
      logic [USER_W-1:0] user;
   } t_rx_seg;

   function automatic t_rx_route f_user_route(input logic [USER_W-1:0] user);
      return user[USER_MMIO_BIT] ? ROUTE_MMIO : ROUTE_CPL;
   endfunction

endpackage

// File: rtl/pcie_rx_tlp_router_if.sv
// Stream interfaces for the RX router: the multi-segment input beat from the
// H-tile bridge and the single-segment output streams.
interface pcie_rx_mc_if;
   import pcie_rx_tlp_router_pkg::*;

   logic                       tvalid;
   logic                       tready;
   logic [NUM_CH-1:0]          seg_valid;
   logic [NUM_CH-1:0]          sop;
   logic [NUM_CH-1:0]          eop;
   logic [NUM_CH*HDR_W-1:0]    hdr;
   logic [NUM_CH*DATA_W-1:0]   payload;
   logic [NUM_CH*USER_W-1:0]   user;

   modport master (output tvalid, seg_valid, sop, eop, hdr, payload, user, input tready);
   modport slave  (input tvalid, seg_valid, sop, eop, hdr, payload, user, output tready);
endinterface

interface pcie_rx_seg_if;
   import pcie_rx_tlp_router_pkg::*;

   logic              tvalid;
   logic              tready;
   logic              sop;
   logic              eop;
   logic [HDR_W-1:0]  hdr;
   logic [DATA_W-1:0] payload;
   logic [USER_W-1:0] user;

   modport master (output tvalid, sop, eop, hdr, payload, user, input tready);
   modport slave  (input tvalid, sop, eop, hdr, payload, user, output tready);
endinterface

// File: rtl/pcie_rx_tlp_router_out_reg.sv
// One-deep valid/ready holding register for a single-segment output stream.
// Contents stay stable while the consumer stalls.
module pcie_rx_out_reg
   import pcie_rx_tlp_router_pkg::*;
(
   input  logic          avl_clk,
   input  logic          avl_rst,
   input  logic          i_load,
   input  t_rx_seg       i_seg,
   output logic          o_can_load,
   pcie_rx_seg_if.master o_out
);

   logic    r_valid;
   t_rx_seg r_seg;

   assign o_can_load = ~r_valid | o_out.tready;

   always_ff @(posedge avl_clk) begin
      if (avl_rst) begin
         r_valid <= 1'b0;
         r_seg   <= '0;
      end else if (o_can_load) begin
         r_valid <= i_load;
         if (i_load) begin
            r_seg <= i_seg;
         end else begin
            r_seg <= r_seg;
         end
      end else begin
         r_valid <= r_valid;
         r_seg   <= r_seg;
      end
   end

   assign o_out.tvalid  = r_valid;
   assign o_out.sop     = r_seg.sop;
   assign o_out.eop     = r_seg.eop;
   assign o_out.hdr     = r_seg.hdr;
   assign o_out.payload = r_seg.payload;
   assign o_out.user    = r_seg.user;

endmodule

// File: rtl/pcie_rx_tlp_router.sv
// Splits each multi-segment RX beat into per-segment transfers and steers every
// TLP to the MMIO or completion stream, keeping per-output order.
module pcie_rx_tlp_router
   import pcie_rx_tlp_router_pkg::*;
(
   input  logic                 avl_clk,
   input  logic                 avl_rst,
   pcie_rx_mc_if.slave          i_rx,
   pcie_rx_seg_if.master        o_mmio,
   pcie_rx_seg_if.master        o_cpl,
   output logic                 orphan_err,
   output logic [ERR_CNT_W-1:0] orphan_cnt
);

   t_rx_seg               r_seg [NUM_CH];
   logic [NUM_CH-1:0]     r_pend;
   logic [NUM_CH-1:0]     r_vmask;
   t_rx_route             r_beat_route;
   logic                  r_beat_active;
   t_rx_route             r_route_q;
   logic                  r_pkt_active;
   logic                  r_orphan_err;
   logic [ERR_CNT_W-1:0]  r_orphan_cnt;

   t_rx_seg               w_in_seg [NUM_CH];
   t_rx_route             w_route [NUM_CH];
   logic [NUM_CH-1:0]     w_orphan;
   logic [NUM_CH-1:0]     w_issue;
   logic                  w_mmio_can;
   logic                  w_cpl_can;
   logic                  w_mmio_load;
   logic                  w_cpl_load;
   t_rx_seg               w_mmio_seg;
   t_rx_seg               w_cpl_seg;
   t_rx_route             w_route_nxt;
   logic                  w_active_nxt;
   logic                  w_in_tready;
   logic                  w_accept;
   logic [ORPH_N_W-1:0]   w_orphan_n;
   logic [ERR_CNT_W:0]    w_cnt_sum;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_in_seg[i].sop     = i_rx.sop[i];
         w_in_seg[i].eop     = i_rx.eop[i];
         w_in_seg[i].hdr     = i_rx.hdr[i*HDR_W +: HDR_W];
         w_in_seg[i].payload = i_rx.payload[i*DATA_W +: DATA_W];
         w_in_seg[i].user    = i_rx.user[i*USER_W +: USER_W];
      end
   end

   // Routes use the packet state captured when the beat loaded, so they cannot
   // shift when a later segment of the same beat issues first.
   always_comb begin
      logic      w_have_sop;
      t_rx_route w_cur;
      w_have_sop = 1'b0;
      w_cur      = r_beat_route;
      w_orphan   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_vmask[i] && r_seg[i].sop) begin
            w_cur      = f_user_route(r_seg[i].user);
            w_have_sop = 1'b1;
         end else begin
            w_orphan[i] = ~w_have_sop & ~r_beat_active;
         end
         w_route[i] = w_cur;
      end
   end

   // Oldest pending segment per destination is the only candidate for it.
   always_comb begin
      logic w_found_m;
      logic w_found_c;
      w_found_m  = 1'b0;
      w_found_c  = 1'b0;
      w_issue    = '0;
      w_mmio_seg = '0;
      w_cpl_seg  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!r_pend[i]) begin
            w_issue[i] = 1'b0;
         end else if (w_orphan[i]) begin
            w_issue[i] = 1'b1;
         end else if (w_route[i] == ROUTE_MMIO) begin
            if (!w_found_m) begin
               w_found_m  = 1'b1;
               w_issue[i] = w_mmio_can;
               w_mmio_seg = r_seg[i];
            end else begin
               w_issue[i] = 1'b0;
            end
         end else begin
            if (!w_found_c) begin
               w_found_c  = 1'b1;
               w_issue[i] = w_cpl_can;
               w_cpl_seg  = r_seg[i];
            end else begin
               w_issue[i] = 1'b0;
            end
         end
      end
      w_mmio_load = w_found_m & w_mmio_can;
      w_cpl_load  = w_found_c & w_cpl_can;
   end

   always_comb begin
      w_route_nxt  = r_route_q;
      w_active_nxt = r_pkt_active;
      w_orphan_n   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_issue[i] && r_seg[i].sop) begin
            w_route_nxt  = w_route[i];
            w_active_nxt = ~r_seg[i].eop;
         end else if (w_issue[i] && r_seg[i].eop) begin
            w_active_nxt = 1'b0;
         end else begin
            w_active_nxt = w_active_nxt;
         end
         if (w_issue[i] && w_orphan[i]) begin
            w_orphan_n = w_orphan_n + ORPH_N_W'(1);
         end else begin
            w_orphan_n = w_orphan_n;
         end
      end
      w_cnt_sum = {1'b0, r_orphan_cnt} + (ERR_CNT_W+1)'(w_orphan_n);
   end

   assign w_in_tready = ~avl_rst & ~|(r_pend & ~w_issue);
   assign w_accept    = i_rx.tvalid & w_in_tready;
   assign i_rx.tready = w_in_tready;

   // A newly accepted beat latches the packet state left by the beat it replaces.
   always_ff @(posedge avl_clk) begin
      if (avl_rst) begin
         r_pend        <= '0;
         r_vmask       <= '0;
         r_beat_route  <= ROUTE_CPL;
         r_beat_active <= 1'b0;
         r_route_q     <= ROUTE_CPL;
         r_pkt_active  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_seg[i] <= '0;
         end
      end else begin
         r_route_q    <= w_route_nxt;
         r_pkt_active <= w_active_nxt;
         if (w_accept) begin
            r_pend        <= i_rx.seg_valid;
            r_vmask       <= i_rx.seg_valid;
            r_seg         <= w_in_seg;
            r_beat_route  <= w_route_nxt;
            r_beat_active <= w_active_nxt;
         end else begin
            r_pend <= r_pend & ~w_issue;
         end
      end
   end

   always_ff @(posedge avl_clk) begin
      if (avl_rst) begin
         r_orphan_err <= 1'b0;
         r_orphan_cnt <= '0;
      end else begin
         r_orphan_err <= |(w_issue & w_orphan);
         if (w_cnt_sum[ERR_CNT_W]) begin
            r_orphan_cnt <= '1;
         end else begin
            r_orphan_cnt <= w_cnt_sum[ERR_CNT_W-1:0];
         end
      end
   end

   assign orphan_err = r_orphan_err;
   assign orphan_cnt = r_orphan_cnt;

   pcie_rx_out_reg u_mmio_reg (
      .avl_clk    (avl_clk),
      .avl_rst    (avl_rst),
      .i_load     (w_mmio_load),
      .i_seg      (w_mmio_seg),
      .o_can_load (w_mmio_can),
      .o_out      (o_mmio)
   );

   pcie_rx_out_reg u_cpl_reg (
      .avl_clk    (avl_clk),
      .avl_rst    (avl_rst),
      .i_load     (w_cpl_load),
      .i_seg      (w_cpl_seg),
      .o_can_load (w_cpl_can),
      .o_out      (o_cpl)
   );

endmodule

// File: tb/tb_pcie_rx_tlp_router.sv
// Directed bench for pcie_rx_tlp_router: reset, routing, ordering, orphan
// counting with saturation, backpressure and mid-packet reset.
module tb_pcie_rx_tlp_router;
   import pcie_rx_tlp_router_pkg::*;

   logic avl_clk = 1'b0;
   logic avl_rst;
   logic orphan_err;
   logic [ERR_CNT_W-1:0] orphan_cnt;
   int n_pass  = 0;
   int n_total = 0;

   always #5 avl_clk = ~avl_clk;

   pcie_rx_mc_if  rx ();
   pcie_rx_seg_if mmio ();
   pcie_rx_seg_if cpl ();

   pcie_rx_tlp_router dut (
      .avl_clk    (avl_clk),
      .avl_rst    (avl_rst),
      .i_rx       (rx),
      .o_mmio     (mmio),
      .o_cpl      (cpl),
      .orphan_err (orphan_err),
      .orphan_cnt (orphan_cnt)
   );

   task automatic tick();
      @(posedge avl_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // v/s/e/m are per-channel seg_valid/sop/eop/mmio bits; d tags hdr and payload.
   task automatic beat(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                       input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1);
      rx.tvalid    = 1'b1;
      rx.seg_valid = v;
      rx.sop       = s;
      rx.eop       = e;
      rx.hdr       = '0;
      rx.payload   = '0;
      rx.user      = '0;
      rx.hdr[0 +: 8]          = d0;
      rx.hdr[HDR_W +: 8]      = d1;
      rx.payload[0 +: 8]      = d0;
      rx.payload[DATA_W +: 8] = d1;
      rx.user[0]      = m[0];
      rx.user[USER_W] = m[1];
   endtask

   task automatic idle();
      rx.tvalid    = 1'b0;
      rx.seg_valid = 2'b00;
      rx.sop       = 2'b00;
      rx.eop       = 2'b00;
      rx.hdr       = '0;
      rx.payload   = '0;
      rx.user      = '0;
   endtask

   initial begin
      avl_rst     = 1'b1;
      mmio.tready = 1'b1;
      cpl.tready  = 1'b1;
      idle();
      repeat (3) tick();
      chk("rst_in_tready", rx.tready, 1'b0);
      chk("rst_mmio_tvalid", mmio.tvalid, 1'b0);
      chk("rst_cpl_tvalid", cpl.tvalid, 1'b0);
      chk("rst_sop_eop", {mmio.sop, mmio.eop, cpl.sop, cpl.eop}, 4'b0000);
      chk("rst_orphan_err", orphan_err, 1'b0);
      chk("rst_orphan_cnt", orphan_cnt, 16'h0000);
      avl_rst = 1'b0;
      tick();
      chk("post_rst_in_tready", rx.tready, 1'b1);

      // MMIO single-cycle TLP on CH0
      beat(2'b01, 2'b01, 2'b01, 2'b01, 8'hA5, 8'h00);
      tick();
      idle();
      chk("mmio1_not_yet", mmio.tvalid, 1'b0);
      tick();
      chk("mmio1_tvalid", mmio.tvalid, 1'b1);
      chk("mmio1_hdr", mmio.hdr, 8'hA5);
      chk("mmio1_sop_eop", {mmio.sop, mmio.eop}, 2'b11);
      chk("mmio1_cpl_idle", cpl.tvalid, 1'b0);
      tick();
      chk("mmio1_one_cycle", mmio.tvalid, 1'b0);

      // Split beats back to back
      beat(2'b11, 2'b11, 2'b11, 2'b01, 8'h11, 8'h22);
      tick();
      beat(2'b11, 2'b11, 2'b11, 2'b01, 8'h33, 8'h44);
      chk("split_tready_a", rx.tready, 1'b1);
      tick();
      idle();
      chk("split_tready_b", rx.tready, 1'b1);
      chk("split1_mmio_hdr", {mmio.tvalid, mmio.hdr}, {1'b1, 128'h11});
      chk("split1_cpl_hdr", {cpl.tvalid, cpl.hdr}, {1'b1, 128'h22});
      tick();
      chk("split2_mmio_hdr", {mmio.tvalid, mmio.hdr}, {1'b1, 128'h33});
      chk("split2_cpl_hdr", {cpl.tvalid, cpl.hdr}, {1'b1, 128'h44});
      tick();
      chk("split_drained", {mmio.tvalid, cpl.tvalid}, 2'b00);

      // Both segments to CPL
      beat(2'b11, 2'b11, 2'b11, 2'b00, 8'h55, 8'h66);
      tick();
      idle();
      chk("same_tready_low", rx.tready, 1'b0);
      tick();
      chk("same_cpl_first", {cpl.tvalid, cpl.hdr}, {1'b1, 128'h55});
      chk("same_tready_back", rx.tready, 1'b1);
      tick();
      chk("same_cpl_second", {cpl.tvalid, cpl.hdr, cpl.eop}, {1'b1, 128'h66, 1'b1});
      chk("same_mmio_idle", mmio.tvalid, 1'b0);
      tick();
      chk("same_drained", cpl.tvalid, 1'b0);

      // Multi-beat CPL packet
      beat(2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'hA1);
      tick();
      beat(2'b11, 2'b00, 2'b10, 2'b00, 8'hB0, 8'hB1);
      tick();
      idle();
      chk("mb_t1", {cpl.tvalid, cpl.sop, cpl.eop, cpl.payload[7:0]}, {3'b110, 8'hA1});
      chk("mb_tready_low", rx.tready, 1'b0);
      tick();
      chk("mb_t2", {cpl.tvalid, cpl.sop, cpl.eop, cpl.payload[7:0]}, {3'b100, 8'hB0});
      tick();
      chk("mb_t3", {cpl.tvalid, cpl.sop, cpl.eop, cpl.payload[7:0]}, {3'b101, 8'hB1});
      chk("mb_mmio_idle", mmio.tvalid, 1'b0);
      tick();
      chk("mb_drained", cpl.tvalid, 1'b0);

      // Orphan right after reset
      avl_rst = 1'b1;
      tick();
      avl_rst = 1'b0;
      beat(2'b01, 2'b00, 2'b01, 2'b00, 8'hC0, 8'h00);
      tick();
      idle();
      tick();
      chk("orph_err", orphan_err, 1'b1);
      chk("orph_cnt", orphan_cnt, 16'h0001);
      chk("orph_no_out", {mmio.tvalid, cpl.tvalid}, 2'b00);
      tick();
      chk("orph_err_pulse", orphan_err, 1'b0);

      // Drive the counter to 0xFFFE, then saturate with double orphans
      beat(2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
      repeat (32766) tick();
      beat(2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
      tick();
      idle();
      tick();
      chk("orph_cnt_fffe", orphan_cnt, 16'hFFFE);
      beat(2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
      tick();
      idle();
      tick();
      chk("orph_sat_err", orphan_err, 1'b1);
      chk("orph_sat_add2", orphan_cnt, 16'hFFFF);
      beat(2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
      tick();
      idle();
      tick();
      chk("orph_sat_hold", orphan_cnt, 16'hFFFF);

      // MMIO stalled while CPL keeps flowing
      mmio.tready = 1'b0;
      beat(2'b01, 2'b01, 2'b01, 2'b01, 8'hD0, 8'h00);
      tick();
      idle();
      tick();
      chk("bp_mmio_held", {mmio.tvalid, mmio.payload[7:0]}, {1'b1, 8'hD0});
      beat(2'b01, 2'b01, 2'b01, 2'b00, 8'hE0, 8'h00);
      tick();
      beat(2'b10, 2'b10, 2'b10, 2'b00, 8'h00, 8'hE1);
      chk("bp_tready", rx.tready, 1'b1);
      tick();
      idle();
      chk("bp_cpl_e0", {cpl.tvalid, cpl.payload[7:0]}, {1'b1, 8'hE0});
      chk("bp_mmio_stable1", {mmio.tvalid, mmio.payload[7:0]}, {1'b1, 8'hD0});
      tick();
      chk("bp_cpl_e1", {cpl.tvalid, cpl.payload[7:0]}, {1'b1, 8'hE1});
      beat(2'b11, 2'b11, 2'b11, 2'b01, 8'hD1, 8'hE2);
      tick();
      idle();
      chk("bp_blocked_tready", rx.tready, 1'b0);
      tick();
      chk("bp_cpl_passes", {cpl.tvalid, cpl.payload[7:0]}, {1'b1, 8'hE2});
      chk("bp_mmio_stable2", {mmio.tvalid, mmio.payload[7:0]}, {1'b1, 8'hD0});
      mmio.tready = 1'b1;
      tick();
      chk("bp_mmio_next", {mmio.tvalid, mmio.payload[7:0]}, {1'b1, 8'hD1});
      tick();
      chk("bp_drained", {mmio.tvalid, cpl.tvalid}, 2'b00);

      // Reset in the middle of a CPL packet
      beat(2'b01, 2'b01, 2'b00, 2'b00, 8'hF0, 8'h00);
      tick();
      idle();
      tick();
      chk("mid_sop_out", {cpl.tvalid, cpl.sop, cpl.payload[7:0]}, {2'b11, 8'hF0});
      avl_rst = 1'b1;
      tick();
      chk("mid_rst_tvalid", {mmio.tvalid, cpl.tvalid}, 2'b00);
      chk("mid_rst_tready", rx.tready, 1'b0);
      avl_rst = 1'b0;
      beat(2'b01, 2'b00, 2'b01, 2'b00, 8'hF1, 8'h00);
      tick();
      idle();
      tick();
      chk("mid_cont_orphan_err", orphan_err, 1'b1);
      chk("mid_cont_orphan_cnt", orphan_cnt, 16'h0001);
      chk("mid_cont_no_out", {mmio.tvalid, cpl.tvalid}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pcie_rx_tlp_router.md
Name: pcie_rx_tlp_router

Overview:
Sits directly downstream of the H-tile RX bridge and consumes its multi-channel AXI4-S RX stream. Each beat carries NUM_CH TLP segments. The block splits every beat into per-segment transfers and routes each TLP to one of two single-segment output streams: MMIO requests (to the CSR/MMIO fabric) and completions/other (to the DMA/AFU mux). Packets are kept intact, and TLP order is preserved within each output.

Parameters:
NUM_CH, 2, TLP segments per input beat.
HDR_W, 128, header width per segment.
DATA_W, 256, payload width per segment.
USER_W, 16, tuser width per segment (mmio_req, vf_active, pfn, vfn, bar packed; bit 0 = mmio_req).
ERR_CNT_W, 16, width of the orphan-segment counter.

Ports:
avl_clk  in  1  clock; all I/O synchronous.
avl_rst  in  1  synchronous, active-high reset.
in_tvalid  in  1  input beat valid.
in_tready  out  1  input beat accepted when in_tvalid & in_tready.
in_seg_valid  in  NUM_CH  per-segment valid.
in_sop  in  NUM_CH  start of TLP.
in_eop  in  NUM_CH  end of TLP.
in_hdr  in  NUM_CH*HDR_W  headers; meaningful on sop only.
in_payload  in  NUM_CH*DATA_W  payload.
in_user  in  NUM_CH*USER_W  tuser.
mmio_tvalid / mmio_tready  out / in  1 each  MMIO output handshake.
mmio_sop, mmio_eop  out  1 each.
mmio_hdr  out  HDR_W.
mmio_payload  out  DATA_W.
mmio_user  out  USER_W.
cpl_tvalid / cpl_tready, cpl_sop, cpl_eop, cpl_hdr, cpl_payload, cpl_user: same as the mmio_* group, for the completion/other output.
orphan_err  out  1  one-cycle pulse when a segment is dropped.
orphan_cnt  out  ERR_CNT_W  saturating count of dropped segments.

Behaviour:
- Reset values: in_tready=0 during reset and 1 the cycle after. All *_tvalid, *_sop, *_eop, orphan_err, orphan_cnt = 0. Internal pkt_active=0, route_q=CPL, buffer empty. Reset mid-packet discards the buffer and in-flight state with no flush.
- Input buffer: one beat register plus a pending mask (NUM_CH bits).
  - Load: in_tvalid & in_tready loads the beat; pending = in_seg_valid.
  - A beat with tvalid=1 and in_seg_valid=0 is accepted and discarded.
  - in_tready = buffer empty OR every pending segment issues this cycle. This allows back-to-back beats.
- Output stages: each output has a single holding register. It can load when ~tvalid | tready. Data is held stable while tvalid & ~tready.
- Latency: input accept at edge N gives output tvalid after edge N+1, provided the output is free.
- Route per pending segment, evaluated in ascending channel order:
  - sop=1: route = user[0] (1 = MMIO, 0 = CPL).
  - sop=0: route = route of the nearest earlier sop segment in the same beat, else route_q if pkt_active.
  - sop=0, no earlier sop in the beat, and pkt_active=0: orphan. The segment is dropped as if issued, orphan_err pulses, and orphan_cnt increments, saturating at all-ones.
- Issue rule, per cycle:
  - Segment i issues if its output can load and no lower pending segment has the same route.
  - At most one segment per output per cycle.
  - A segment bound for a free output may issue past a lower segment blocked on the other output. Cross-output order is not preserved.
  - Issued segments clear their pending bit.
- State update, applied per issued segment in channel order: sop sets route_q = route; pkt_active = ~eop at sop; eop clears pkt_active.
- A new sop while pkt_active=1 starts a new packet; the previous packet is truncated. No error is flagged.
- Throughput: 1 beat/cycle when the segments of a beat target distinct outputs. NUM_CH cycles per beat when all segments target one output.
- Simultaneous orphans in one beat: orphan_cnt adds the count of orphans, saturating. orphan_err is a single pulse.

Decomposition:
- ofs_fim_pcie_pkg additions:
  - t_rx_route enum {ROUTE_CPL, ROUTE_MMIO}.
  - t_rx_seg struct {sop, eop, hdr, payload, user}.
  - USER_MMIO_BIT=0.
- Sub-module: pcie_rx_out_reg, a one-deep valid/ready holding register. It is instantiated twice, once per output.

Test Plan:
- MMIO single-cycle: CH0 sop=eop=1, user[0]=1, hdr=0xA5 → mmio_tvalid one cycle, 2 cycles after accept, hdr=0xA5, sop=eop=1. cpl_tvalid stays 0.
- Split beat: CH0 MMIO sop/eop, CH1 CPL sop/eop → both outputs valid in the same cycle; in_tready never drops.
- Same-destination beat: CH0 and CH1 both CPL sop/eop → cpl emits CH0 then CH1 on consecutive cycles; in_tready=0 for exactly 1 cycle.
- Multi-beat CPL: beat 1 CH1 sop, beat 2 CH0 mid, CH1 eop → 3 cpl transfers in order, eop on the third; mmio idle.
- Orphan: after reset, CH0 sop=0 eop=1 → no output; orphan_err pulses once; orphan_cnt=1. With orphan_cnt preloaded to 0xFFFF, a further orphan leaves it at 0xFFFF.
- Backpressure/reset: mmio_tready=0 holding an MMIO segment, CPL traffic keeps flowing; mmio_payload stable. avl_rst mid-packet → all tvalid=0 next cycle; a following continuation segment is treated as an orphan.
